// File: rtl/accum_pkg.sv
// Shared types and constants for the streaming accumulator.
// FSM encoding plus signed-limit helpers keyed by operand width.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ACC_W_MAX = 64;

  // Largest positive two's-complement value for an n-bit word.
  function automatic logic [ACC_W_MAX-1:0] smax_f(input int n);
    smax_f = (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [ACC_W_MAX-1:0] smin_f(input int n);
    smin_f = 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/accum_nbit_addsub_core.sv
// Combinational N-bit add/subtract with carry-out and carry into the MSB.
// Subtract is a + ~b + 1 so cout is the inverted borrow.
module addsub_core #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [N-1:0] bx;
  logic [N-1:0] lo;
  logic [1:0]   hi;

  assign bx = sub_i ? ~b_i : b_i;

  assign lo = {1'b0, a_i[N-2:0]}
            + {1'b0, bx[N-2:0]}
            + {{(N-1){1'b0}}, sub_i};

  assign c_msb_o = lo[N-1];

  assign hi = {1'b0, a_i[N-1]}
            + {1'b0, bx[N-1]}
            + {1'b0, c_msb_o};

  assign sum_o  = {hi[0], lo[N-2:0]};
  assign cout_o = hi[1];

endmodule

// File: rtl/accum_nbit.sv
// Streaming add/sub accumulator with sticky carry/overflow and beat count.
// Define ACCUM_NBIT_SAT_EN to clamp on signed overflow instead of wrapping.
module accum_nbit
  import accum_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  state_e state_q, state_d;

  logic [N-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0] sum;
  logic         cout;
  logic         c_msb;
  logic         b_carry;
  logic         b_ovf;
  logic [N-1:0] res;
  logic         accept;
  logic         take;

  addsub_core #(.N(N)) u_core (
    .a_i    (acc_q),
    .b_i    (in_data),
    .sub_i  (in_sub),
    .sum_o  (sum),
    .cout_o (cout),
    .c_msb_o(c_msb)
  );

  assign accept  = in_valid && in_ready;
  assign take    = out_valid && out_ready;
  assign b_carry = (!in_sub && cout) || (in_sub && !cout);
  assign b_ovf   = c_msb ^ cout;

`ifdef ACCUM_NBIT_SAT_EN
  localparam logic [N-1:0] SMAX = N'(smax_f(N));
  localparam logic [N-1:0] SMIN = N'(smin_f(N));

  // Clamp direction follows the sign of the pre-add total.
  always_comb begin
    res = sum;
    if (b_ovf) res = acc_q[N-1] ? SMIN : SMAX;
  end
`else
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: if (accept) state_d = in_last ? DONE : ACC;
      DONE:      if (take) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE, ACC: in_ready = 1'b1;
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      acc_d   = res;
      carry_d = carry_q | b_carry;
      ovf_d   = ovf_q | b_ovf;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (take) begin
      acc_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_accum_nbit.sv
// Directed bench for accum_nbit at N=8, CNT_W=4.
// Expected values are hand-computed; SAT-dependent ones follow ACCUM_NBIT_SAT_EN.
module tb_accum_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sub;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_ovf;
  logic [3:0] out_count;

  int total = 0;
  int pass  = 0;

  accum_nbit #(.N(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum"}, 32'(out_sum), 32'h00);
    chk({tag, "_cy"}, 32'(out_carry), 32'd0);
    chk({tag, "_ov"}, 32'(out_ovf), 32'd0);
    chk({tag, "_cnt"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_ovf1;
    logic [7:0] exp_ovf2;
`ifdef ACCUM_NBIT_SAT_EN
    exp_ovf1 = 8'h7F;
    exp_ovf2 = 8'h7F;
`else
    exp_ovf1 = 8'h80;
    exp_ovf2 = 8'h81;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");

    beat(8'd3, 1'b0, 1'b0);
    beat(8'd5, 1'b0, 1'b0);
    chk("t1_pre_vld", 32'(out_valid), 32'd0);
    beat(8'd7, 1'b0, 1'b1);
    chk("t1_vld", 32'(out_valid), 32'd1);
    chk("t1_rdy", 32'(in_ready), 32'd0);
    chk("t1_sum", 32'(out_sum), 32'h0F);
    chk("t1_cy", 32'(out_carry), 32'd0);
    chk("t1_ov", 32'(out_ovf), 32'd0);
    chk("t1_cnt", 32'(out_count), 32'd3);
    consume();
    chk_idle("t1_clr");

    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    chk("t2_sum", 32'(out_sum), 32'h00);
    chk("t2_cy", 32'(out_carry), 32'd1);
    chk("t2_ov", 32'(out_ovf), 32'd0);
    consume();

    beat(8'h7F, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    chk("t3_sum", 32'(out_sum), 32'(exp_ovf1));
    chk("t3_cy", 32'(out_carry), 32'd0);
    chk("t3_ov", 32'(out_ovf), 32'd1);
    consume();

    beat(8'h7F, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    chk("t3b_sum", 32'(out_sum), 32'(exp_ovf2));
    chk("t3b_ov_sticky", 32'(out_ovf), 32'd1);
    consume();

    beat(8'h05, 1'b0, 1'b0);
    beat(8'h07, 1'b1, 1'b1);
    chk("t4_sum", 32'(out_sum), 32'hFE);
    chk("t4_cy", 32'(out_carry), 32'd1);
    chk("t4_ov", 32'(out_ovf), 32'd0);
    chk("t4_cnt", 32'(out_count), 32'd2);

    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_vld", 32'(out_valid), 32'd1);
      chk("t5_hold_rdy", 32'(in_ready), 32'd0);
      chk("t5_hold_sum", 32'(out_sum), 32'hFE);
      chk("t5_hold_cnt", 32'(out_count), 32'd2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume();
    chk_idle("t5_clr");

    for (int i = 0; i < 16; i++) beat(8'h01, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    chk("t6_sat_cnt", 32'(out_count), 32'd15);
    chk("t6_sum", 32'(out_sum), 32'h11);
    consume();

    beat(8'd9, 1'b0, 1'b0);
    beat(8'd9, 1'b0, 1'b0);
    chk("t7_mid_sum", 32'(out_sum), 32'h12);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd9;
    in_last  = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_idle("t7_rst");
    beat(8'd4, 1'b0, 1'b1);
    chk("t7_vld", 32'(out_valid), 32'd1);
    chk("t7_sum", 32'(out_sum), 32'h04);
    chk("t7_cnt", 32'(out_count), 32'd1);

    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk_idle("t8_rst_done");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
